// File: rtl/xadc_packetizer_pkg.sv
// Shared types and constants for the XADC frame packetizer.
package xadc_packetizer_pkg;

  typedef enum logic [2:0] {
    IDLE, SYNC, SEQ, CH0_HI, CH0_LO, CH1_HI, CH1_LO
  } packetizer_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_BYTES   = 6;

  // Upper sample bits [11:8] in the low nibble; bits above the sample never leak out.
  function automatic logic [7:0] hi_byte(input logic [15:0] s);
    return {4'h0, s[11:8]};
  endfunction

  function automatic logic [7:0] lo_byte(input logic [15:0] s);
    return s[7:0];
  endfunction

endpackage

// File: rtl/xadc_packetizer_if.sv
// AXI-Stream byte channel between the packetizer and the USB FIFO sink.
interface xadc_packetizer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/xadc_packetizer.sv
// Frames ch0/ch1 sample pairs into 6-byte packets with a sequence number,
// one in-flight frame plus a one-deep pending slot, and overrun accounting.
module xadc_packetizer
  import xadc_packetizer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         SAMPLE_W   = 12,
  parameter int         DROP_CNT_W = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_ch0,
  input  logic [SAMPLE_W-1:0]   sample_ch1,
  xadc_packetizer_if.master     m_axis,
  output logic                  overrun,
  output logic [DROP_CNT_W-1:0] drop_count
);

  packetizer_state_t     state_q, state_d;
  logic [SAMPLE_W-1:0]   frm0_q, frm0_d, frm1_q, frm1_d;
  logic [SAMPLE_W-1:0]   pnd0_q, pnd0_d, pnd1_q, pnd1_d;
  logic                  pnd_vld_q, pnd_vld_d;
  logic [7:0]            seq_q, seq_d;
  logic                  ovr_q, ovr_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic tvalid, hs, frame_done;

  assign tvalid     = (state_q != IDLE);
  assign hs         = tvalid && m_axis.tready;
  assign frame_done = hs && (state_q == CH1_LO);

  // State, frame, pending and counters registered together; reset abandons any partial frame.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      frm0_q    <= '0;
      frm1_q    <= '0;
      pnd0_q    <= '0;
      pnd1_q    <= '0;
      pnd_vld_q <= 1'b0;
      seq_q     <= '0;
      ovr_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      frm0_q    <= frm0_d;
      frm1_q    <= frm1_d;
      pnd0_q    <= pnd0_d;
      pnd1_q    <= pnd1_d;
      pnd_vld_q <= pnd_vld_d;
      seq_q     <= seq_d;
      ovr_q     <= ovr_d;
      drop_q    <= drop_d;
    end
  end

  // Next state: the frame register loads only when entering SYNC (from IDLE or end of frame).
  always_comb begin
    state_d   = state_q;
    frm0_d    = frm0_q;
    frm1_d    = frm1_q;
    pnd0_d    = pnd0_q;
    pnd1_d    = pnd1_q;
    pnd_vld_d = pnd_vld_q;
    seq_d     = seq_q;
    ovr_d     = ovr_q;
    drop_d    = drop_q;
    if (state_q == IDLE || frame_done) begin
      if (frame_done) seq_d = seq_q + 8'd1;
      if (pnd_vld_q) begin
        // Oldest pair first; a same-cycle strobe refills the pending slot, so nothing drops.
        state_d   = SYNC;
        frm0_d    = pnd0_q;
        frm1_d    = pnd1_q;
        pnd_vld_d = sample_valid;
        if (sample_valid) begin
          pnd0_d = sample_ch0;
          pnd1_d = sample_ch1;
        end
      end else if (sample_valid) begin
        state_d = SYNC;
        frm0_d  = sample_ch0;
        frm1_d  = sample_ch1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (hs) begin
        unique case (state_q)
          SYNC:    state_d = SEQ;
          SEQ:     state_d = CH0_HI;
          CH0_HI:  state_d = CH0_LO;
          CH0_LO:  state_d = CH1_HI;
          CH1_HI:  state_d = CH1_LO;
          default: state_d = state_q;
        endcase
      end
      if (sample_valid) begin
        if (!pnd_vld_q) begin
          pnd_vld_d = 1'b1;
          pnd0_d    = sample_ch0;
          pnd1_d    = sample_ch1;
        end else begin
          ovr_d = 1'b1;
          if (~&drop_q) drop_d = drop_q + DROP_CNT_W'(1);
        end
      end
    end
  end

  // Byte mux from latched frame data; outputs are zero while idle.
  always_comb begin
    m_axis.tvalid = tvalid;
    m_axis.tlast  = (state_q == CH1_LO);
    unique case (state_q)
      SYNC:    m_axis.tdata = SYNC_BYTE;
      SEQ:     m_axis.tdata = seq_q;
      CH0_HI:  m_axis.tdata = hi_byte(16'(frm0_q));
      CH0_LO:  m_axis.tdata = lo_byte(16'(frm0_q));
      CH1_HI:  m_axis.tdata = hi_byte(16'(frm1_q));
      CH1_LO:  m_axis.tdata = lo_byte(16'(frm1_q));
      default: m_axis.tdata = 8'h00;
    endcase
  end

  assign overrun    = ovr_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_xadc_packetizer.sv
// Self-checking bench for xadc_packetizer: frame-level reference model plus
// table-driven frames and directed stall/overrun/wrap/reset sequences.
module tb_xadc_packetizer;
  import xadc_packetizer_pkg::*;

  localparam logic [7:0] SB = 8'hA5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample_ch0 = '0;
  logic [11:0] sample_ch1 = '0;
  logic        overrun;
  logic [15:0] drop_count;

  xadc_packetizer_if m_axis();

  xadc_packetizer #(.SYNC_BYTE(SB), .SAMPLE_W(12), .DROP_CNT_W(16)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sample_valid (sample_valid),
    .sample_ch0   (sample_ch0),
    .sample_ch1   (sample_ch1),
    .m_axis       (m_axis),
    .overrun      (overrun),
    .drop_count   (drop_count)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct { logic [7:0] b; logic last; } xb_t;
  xb_t        exp_q[$];
  logic [7:0] obs_q[$];
  int         outst = 0;       // accepted pairs not yet fully sent
  logic [7:0] seq_m = 8'h00;
  logic [15:0] drops_m = '0;
  logic       ovr_m = 1'b0;
  bit         exp_sync = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;

  task automatic push_frame(input logic [11:0] c0, input logic [11:0] c1, input logic [7:0] s);
    exp_q.push_back('{SB, 1'b0});
    exp_q.push_back('{s, 1'b0});
    exp_q.push_back('{{4'h0, c0[11:8]}, 1'b0});
    exp_q.push_back('{c0[7:0], 1'b0});
    exp_q.push_back('{{4'h0, c1[11:8]}, 1'b0});
    exp_q.push_back('{c1[7:0], 1'b1});
  endtask

  // Evaluated mid-cycle: checks current outputs, then predicts the coming edge.
  always @(negedge sys_clk) begin
    int done;
    int acc;
    chk("drop_count", 32'(drop_count), 32'(drops_m));
    chk("overrun", 32'(overrun), 32'(ovr_m));
    chk("tvalid_busy", 32'(m_axis.tvalid), (outst != 0) ? 32'd1 : 32'd0);
    if (exp_sync) chk("sync_latency", {23'd0, m_axis.tvalid, m_axis.tdata}, {23'd0, 1'b1, SB});
    if (prev_stall) chk("stall_hold", 32'(m_axis.tdata), 32'(prev_data));
    if (!sys_rst_n) begin
      exp_q.delete();
      outst = 0; seq_m = 8'h00; drops_m = '0; ovr_m = 1'b0;
      exp_sync = 0; prev_stall = 0;
    end else begin
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_data  = m_axis.tdata;
      done = 0; acc = 0;
      if (m_axis.tvalid && m_axis.tready) begin
        obs_q.push_back(m_axis.tdata);
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(m_axis.tdata), 32'hFFFF_FFFF);
        else begin
          chk("byte", 32'(m_axis.tdata), 32'(exp_q[0].b));
          chk("tlast", 32'(m_axis.tlast), 32'(exp_q[0].last));
          done = exp_q[0].last ? 1 : 0;
          void'(exp_q.pop_front());
        end
      end
      exp_sync = 0;
      if (sample_valid) begin
        if (outst - done < 2) begin
          acc = 1;
          if (outst - done == 0) exp_sync = 1;
          push_frame(sample_ch0, sample_ch1, seq_m);
          seq_m = seq_m + 8'd1;
        end else begin
          ovr_m = 1'b1;
          if (drops_m != 16'hFFFF) drops_m = drops_m + 16'd1;
        end
      end
      outst = outst - done + acc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic strobe(input logic [11:0] c0, input logic [11:0] c1);
    sample_valid = 1'b1; sample_ch0 = c0; sample_ch1 = c1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((outst != 0 || m_axis.tvalid) && n < max) begin tick(); n++; end
    if (n >= max) chk("wait_idle_timeout", 32'(n), 32'(max - 1));
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick(); tick();
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [11:0] c0, c1;
    logic [7:0]  h0, l0, h1, l1;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int base;
    int bad;
    logic [15:0] drop_before;
    vecs[0] = '{12'h123, 12'hABC, 8'h01, 8'h23, 8'h0A, 8'hBC};
    vecs[1] = '{12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{12'hFFF, 12'hFFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF};
    vecs[3] = '{12'h800, 12'h001, 8'h08, 8'h00, 8'h00, 8'h01};
    vecs[4] = '{12'h5A5, 12'hA5A, 8'h05, 8'hA5, 8'h0A, 8'h5A};

    m_axis.tready = 1'b1;
    do_reset();
    // reset state
    chk("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis.tlast), 32'd0);
    chk("rst_tdata", 32'(m_axis.tdata), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // table-driven single frames, tready held high
    for (int i = 0; i < 5; i++) begin
      obs_q.delete();
      strobe(vecs[i].c0, vecs[i].c1);
      wait_idle(20);
      chk("tbl_len", 32'(obs_q.size()), 32'd6);
      if (obs_q.size() == 6) begin
        chk("tbl_sync", 32'(obs_q[0]), 32'(SB));
        chk("tbl_seq", 32'(obs_q[1]), 32'(i));
        chk("tbl_h0", 32'(obs_q[2]), 32'(vecs[i].h0));
        chk("tbl_l0", 32'(obs_q[3]), 32'(vecs[i].l0));
        chk("tbl_h1", 32'(obs_q[4]), 32'(vecs[i].h1));
        chk("tbl_l1", 32'(obs_q[5]), 32'(vecs[i].l1));
      end
    end

    // tready toggling every cycle: same bytes, data held on stalls
    obs_q.delete();
    strobe(vecs[0].c0, vecs[0].c1);
    for (int c = 0; c < 40 && (outst != 0 || m_axis.tvalid); c++) begin
      m_axis.tready = ~m_axis.tready;
      tick();
    end
    m_axis.tready = 1'b1;
    chk("tog_len", 32'(obs_q.size()), 32'd6);
    if (obs_q.size() == 6) begin
      chk("tog_sync", 32'(obs_q[0]), 32'(SB));
      chk("tog_seq", 32'(obs_q[1]), 32'd5);
      chk("tog_l0", 32'(obs_q[3]), 32'h23);
      chk("tog_l1", 32'(obs_q[5]), 32'hBC);
    end

    // stalled sink, three strobes: third is dropped
    m_axis.tready = 1'b0;
    obs_q.delete();
    strobe(12'h111, 12'h222);
    strobe(12'h333, 12'h444);
    strobe(12'h555, 12'h666);
    tick();
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_drop", 32'(drop_count), 32'd1);
    m_axis.tready = 1'b1;
    wait_idle(40);
    chk("ovr_len", 32'(obs_q.size()), 32'd12);
    if (obs_q.size() == 12) begin
      chk("ovr_f1", 32'(obs_q[3]), 32'h11);
      chk("ovr_f2", 32'(obs_q[9]), 32'h33);
      chk("ovr_seq", 32'(obs_q[7]), 32'(obs_q[1] + 8'd1));
    end

    // strobe on CH1_LO handshake with pending full: no drop, order kept
    drop_before = drop_count;
    obs_q.delete();
    strobe(12'h0A1, 12'h0B1);
    strobe(12'h0A2, 12'h0B2);
    for (int c = 0; c < 20 && !(m_axis.tvalid && m_axis.tlast); c++) tick();
    strobe(12'h0A3, 12'h0B3);
    wait_idle(40);
    chk("edge_drop", 32'(drop_count), 32'(drop_before));
    chk("edge_len", 32'(obs_q.size()), 32'd18);
    if (obs_q.size() == 18) begin
      chk("edge_d3", 32'(obs_q[15]), 32'hA3);
      chk("edge_seq2", 32'(obs_q[7]), 32'(obs_q[1] + 8'd1));
      chk("edge_seq3", 32'(obs_q[13]), 32'(obs_q[1] + 8'd2));
    end

    // 257 back-to-back frames: sequence wraps FF -> 00
    do_reset();
    obs_q.delete();
    for (int f = 0; f < 257; f++) begin
      strobe(12'(f), 12'(f * 3));
      repeat (5) tick();
    end
    wait_idle(20);
    chk("wrap_len", 32'(obs_q.size()), 32'(257 * FRAME_BYTES));
    bad = 0;
    if (obs_q.size() == 257 * FRAME_BYTES)
      for (int f = 0; f < 257; f++) if (obs_q[f * 6 + 1] != 8'(f)) bad++;
    chk("wrap_seq_all", 32'(bad), 32'd0);
    if (obs_q.size() == 257 * FRAME_BYTES) begin
      chk("wrap_ff", 32'(obs_q[255 * 6 + 1]), 32'hFF);
      chk("wrap_00", 32'(obs_q[256 * 6 + 1]), 32'h00);
    end
    chk("wrap_drop", 32'(drop_count), 32'd0);

    // reset mid-frame during stalled CH0_LO
    obs_q.delete();
    strobe(12'h123, 12'hABC);
    for (int c = 0; c < 20 && obs_q.size() < 3; c++) tick();
    m_axis.tready = 1'b0;
    tick();
    chk("mid_stall_data", 32'(m_axis.tdata), 32'h23);
    sys_rst_n = 1'b0;
    tick();
    chk("mid_rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("mid_rst_tdata", 32'(m_axis.tdata), 32'd0);
    chk("mid_rst_tlast", 32'(m_axis.tlast), 32'd0);
    sys_rst_n = 1'b1;
    m_axis.tready = 1'b1;
    obs_q.delete();
    strobe(12'h456, 12'h789);
    wait_idle(20);
    chk("mid_len", 32'(obs_q.size()), 32'd6);
    if (obs_q.size() == 6) begin
      chk("mid_sync", 32'(obs_q[0]), 32'(SB));
      chk("mid_seq", 32'(obs_q[1]), 32'd0);
      chk("mid_l0", 32'(obs_q[3]), 32'h56);
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      m_axis.tready = ($urandom_range(0, 9) < 7);
      sample_valid  = ($urandom_range(0, 9) < 2);
      sample_ch0    = 12'($urandom);
      sample_ch1    = 12'($urandom);
      tick();
    end
    sample_valid  = 1'b0;
    m_axis.tready = 1'b1;
    wait_idle(100);
    chk("rand_drop", 32'(drop_count), 32'(drops_m));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
